// File: rtl/mux_n_to_1_pipe.sv
// N-input, WIDTH-bit registered selector with valid/ready handshake and illegal-select flagging.
// Define MUX_ERR_CNT_EN to build the saturating illegal-select counter behind err_count.
module mux_n_to_1_pipe #(
    parameter int              WIDTH   = 32,
    parameter int              INPUTS  = 3,
    parameter int              SEL_W   = 2,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INPUTS*WIDTH-1:0] inputs,
    input  logic [SEL_W-1:0]        signal,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_error,
    output logic [7:0]              err_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             sel_error_reg;

    logic [INPUTS-1:0] hit;
    logic [WIDTH-1:0]  slot [INPUTS];
    logic [WIDTH-1:0]  sel_data;
    logic              illegal;
    logic              load;
    logic              drain;

    // One-hot decode of the select; no hit at all means the code is out of range.
    generate
        for (genvar gi = 0; gi < INPUTS; gi++) begin : g_slot
            assign slot[gi] = inputs[gi*WIDTH +: WIDTH];
            assign hit[gi]  = (signal == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        sel_data = DEFAULT;
        for (int k = 0; k < INPUTS; k++) begin
            if (hit[k]) begin
                sel_data = slot[k];
            end
        end
    end

    assign illegal  = ~|hit;
    assign in_ready = !reset && ((state_reg == EMPTY) || out_ready);
    assign load     = in_valid && in_ready;
    assign drain    = (state_reg == FULL) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            result_reg    <= '0;
            sel_error_reg <= 1'b0;
        end else begin
            if (load) begin
                result_reg <= sel_data;
                state_reg  <= FULL;
                if (illegal) begin
                    sel_error_reg <= 1'b1;
                end
            end else if (drain) begin
                // Result keeps its last value once consumed.
                state_reg <= EMPTY;
            end
        end
    end

    assign result    = result_reg;
    assign out_valid = (state_reg == FULL);
    assign sel_error = sel_error_reg;

`ifdef MUX_ERR_CNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= 8'd0;
        end else if (load && illegal && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

endmodule
